// File: rtl/fpgaboy_pkg.sv
// Shared LCD geometry and writer state encoding.
// The scan-out side imports the same constants so both agree on frame layout.
package fpgaboy_pkg;

  localparam int H_PIXELS   = 160;
  localparam int V_LINES    = 144;
  localparam int ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } lcd_writer_state_t;

endpackage

// File: rtl/lcd_frame_writer_edge_detect.sv
// Rise/fall strobes for a level input, based on one registered copy of it.
// The input is already synchronous to clk_in, so no synchroniser stages are needed.
module edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic rise_out,
  output logic fall_out
);

  logic r_prev;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_prev <= 1'b0;
    else         r_prev <= sig_in;
  end

  assign rise_out = sig_in & ~r_prev;
  assign fall_out = ~sig_in & r_prev;

endmodule

// File: rtl/lcd_frame_writer.sv
// Writes the PPU shade stream into the back bank of a double-buffered
// framebuffer, and swaps banks only when a complete, well-formed frame ends.
module lcd_frame_writer
  import fpgaboy_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            pixel_in,
  input  logic                  pixel_valid_in,
  input  logic                  hblank_in,
  input  logic                  vblank_in,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [1:0]            wr_data_out,
  output logic                  wr_en_out,
  output logic                  wr_bank_out,
  output logic                  frame_done_out,
  output logic                  line_error_out,
  output logic                  frame_error_out
);

  localparam int X_W = $clog2(H_PIXELS + 1);
  localparam int Y_W = $clog2(V_LINES + 2);
  localparam logic [X_W-1:0]        X_END     = X_W'(H_PIXELS);
  localparam logic [X_W-1:0]        X_ONE     = X_W'(1);
  localparam logic [Y_W-1:0]        Y_END     = Y_W'(V_LINES);
  localparam logic [Y_W-1:0]        Y_ONE     = Y_W'(1);
  localparam logic [Y_W-1:0]        Y_MAX     = '1;
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);

  lcd_writer_state_t r_state, w_state_nx;
  logic [X_W-1:0]        r_x, w_x_nx;
  logic [Y_W-1:0]        r_y, w_y_nx;
  logic [ADDR_WIDTH-1:0] r_line_base, w_line_base_nx;
  logic                  r_line_bad, w_line_bad_nx;
  logic                  r_frame_bad, w_frame_bad_nx;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nx;
  logic [1:0]            r_wr_data, w_wr_data_nx;
  logic                  r_wr_en, w_wr_en_nx;
  logic                  r_wr_bank, w_wr_bank_nx;
  logic                  r_frame_done, w_frame_done_nx;
  logic                  r_line_error, w_line_error_nx;
  logic                  r_frame_error, w_frame_error_nx;
  logic                  w_hb_rise, w_hb_fall, w_vb_rise, w_vb_fall;

  edge_detect u_hblank_edge (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .sig_in  (hblank_in),
    .rise_out(w_hb_rise),
    .fall_out(w_hb_fall)
  );

  edge_detect u_vblank_edge (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .sig_in  (vblank_in),
    .rise_out(w_vb_rise),
    .fall_out(w_vb_fall)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    w_state_nx       = r_state;
    w_x_nx           = r_x;
    w_y_nx           = r_y;
    w_line_base_nx   = r_line_base;
    w_line_bad_nx    = r_line_bad;
    w_frame_bad_nx   = r_frame_bad;
    w_wr_addr_nx     = r_wr_addr;
    w_wr_data_nx     = r_wr_data;
    w_wr_en_nx       = 1'b0;
    w_wr_bank_nx     = r_wr_bank;
    w_frame_done_nx  = 1'b0;
    w_line_error_nx  = r_line_error;
    w_frame_error_nx = 1'b0;

    // Pixel accounting happens before line/frame closing, so a strobe that
    // coincides with an hblank edge still counts toward the line it ends.
    if (pixel_valid_in) begin
      if (r_state == ST_ACTIVE) begin
        if (r_x == X_END) begin
          w_line_bad_nx = 1'b1;
        end else begin
          w_x_nx = r_x + X_ONE;
          if (r_y < Y_END) begin
            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = r_line_base + ADDR_WIDTH'(r_x);
            w_wr_data_nx = pixel_in;
          end else begin
            w_frame_bad_nx = 1'b1;
          end
        end
      end else if (r_state == ST_HBLANK) begin
        w_line_bad_nx = 1'b1;
      end
    end

    unique case (r_state)
      ST_SYNC, ST_VBLANK: begin
        if (w_vb_fall) begin
          w_state_nx      = ST_ACTIVE;
          w_x_nx          = '0;
          w_y_nx          = '0;
          w_line_base_nx  = '0;
          w_line_bad_nx   = 1'b0;
          w_frame_bad_nx  = 1'b0;
          w_line_error_nx = 1'b0;
        end
      end
      ST_ACTIVE, ST_HBLANK: begin
        if (w_vb_rise) begin
          w_state_nx = ST_VBLANK;
          if (r_y == Y_END && !w_line_error_nx && !w_line_bad_nx && !w_frame_bad_nx) begin
            w_wr_bank_nx    = ~r_wr_bank;
            w_frame_done_nx = 1'b1;
          end else begin
            w_frame_error_nx = 1'b1;
          end
        end else if (r_state == ST_ACTIVE && w_hb_rise) begin
          w_state_nx = ST_HBLANK;
          if (w_x_nx != X_END || w_line_bad_nx) w_line_error_nx = 1'b1;
          w_line_bad_nx = 1'b0;
          w_x_nx        = '0;
          if (r_y < Y_END) w_line_base_nx = r_line_base + LINE_STEP;
          if (r_y != Y_MAX) w_y_nx = r_y + Y_ONE;
        end else if (r_state == ST_HBLANK && w_hb_fall && !vblank_in) begin
          w_state_nx = ST_ACTIVE;
        end
      end
      default: w_state_nx = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= ST_SYNC;
      r_x           <= '0;
      r_y           <= '0;
      r_line_base   <= '0;
      r_line_bad    <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_en       <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_error  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_x           <= w_x_nx;
      r_y           <= w_y_nx;
      r_line_base   <= w_line_base_nx;
      r_line_bad    <= w_line_bad_nx;
      r_frame_bad   <= w_frame_bad_nx;
      r_wr_addr     <= w_wr_addr_nx;
      r_wr_data     <= w_wr_data_nx;
      r_wr_en       <= w_wr_en_nx;
      r_wr_bank     <= w_wr_bank_nx;
      r_frame_done  <= w_frame_done_nx;
      r_line_error  <= w_line_error_nx;
      r_frame_error <= w_frame_error_nx;
    end
  end

  assign wr_addr_out     = r_wr_addr;
  assign wr_data_out     = r_wr_data;
  assign wr_en_out       = r_wr_en;
  assign wr_bank_out     = r_wr_bank;
  assign frame_done_out  = r_frame_done;
  assign line_error_out  = r_line_error;
  assign frame_error_out = r_frame_error;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer: directed frames push expected writes
// and frame events; a negedge monitor pops and compares whatever the DUT emits.
module tb_lcd_frame_writer;

  localparam int H = 160;
  localparam int V = 144;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  pixel_in;
  logic        pixel_valid_in;
  logic        hblank_in;
  logic        vblank_in;
  logic [14:0] wr_addr_out;
  logic [1:0]  wr_data_out;
  logic        wr_en_out;
  logic        wr_bank_out;
  logic        frame_done_out;
  logic        line_error_out;
  logic        frame_error_out;

  typedef struct {
    logic [14:0] addr;
    logic [1:0]  data;
  } wr_t;

  typedef struct {
    logic done;
    logic bank;
  } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  lcd_frame_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .hblank_in      (hblank_in),
    .vblank_in      (vblank_in),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .wr_en_out      (wr_en_out),
    .wr_bank_out    (wr_bank_out),
    .frame_done_out (frame_done_out),
    .line_error_out (line_error_out),
    .frame_error_out(frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] pat(input int x, input int y);
    return 2'(x + 3 * y);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One visible line: n strobes, optionally with the last one on the hblank rise.
  task automatic do_line(input int y, input int n, input bit coincide);
    for (int x = 0; x < n; x++) begin
      pixel_in       = pat(x, y);
      pixel_valid_in = 1'b1;
      if (x < H && y < V) wr_q.push_back('{addr: 15'(y * H + x), data: pat(x, y)});
      if (coincide && x == n - 1) hblank_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    if (!coincide) begin
      hblank_in = 1'b1;
      tick();
    end
    hblank_in = 1'b0;
    tick();
  endtask

  task automatic do_vblank(input bit exp_event, input bit exp_done, input bit exp_bank);
    if (exp_event) ev_q.push_back('{done: exp_done, bank: exp_bank});
    vblank_in = 1'b1;
    tick();
    tick();
    vblank_in = 1'b0;
    tick();
  endtask

  task automatic stray_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_in       = 2'(i + 1);
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_addr"},     32'(wr_addr_out),     32'd0);
    check({tag, "_wr_data"},     32'(wr_data_out),     32'd0);
    check({tag, "_wr_en"},       32'(wr_en_out),       32'd0);
    check({tag, "_wr_bank"},     32'(wr_bank_out),     32'd0);
    check({tag, "_frame_done"},  32'(frame_done_out),  32'd0);
    check({tag, "_line_error"},  32'(line_error_out),  32'd0);
    check({tag, "_frame_error"}, 32'(frame_error_out), 32'd0);
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (wr_en_out) begin
        if (wr_q.size() == 0) begin
          check("spurious_write_addr", 32'(wr_addr_out), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr_out), 32'(w.addr));
          check("wr_data", 32'(wr_data_out), 32'(w.data));
        end
      end
      if (frame_done_out || frame_error_out) begin
        if (ev_q.size() == 0) begin
          check("spurious_frame_event", {30'd0, frame_done_out, frame_error_out}, 32'd0);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          check("frame_done",    32'(frame_done_out),  32'(e.done));
          check("frame_error",   32'(frame_error_out), 32'(!e.done));
          check("bank_at_event", 32'(wr_bank_out),     32'(e.bank));
        end
      end
    end
  end

  initial begin
    rst_in         = 1'b0;
    pixel_in       = 2'd0;
    pixel_valid_in = 1'b0;
    hblank_in      = 1'b0;
    vblank_in      = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_in = 1'b1;
    tick();

    // Pixels before the first vblank falling edge are ignored.
    stray_pixels(3);
    do_vblank(1'b0, 1'b0, 1'b0);

    // Frame 1: clean, ends with a swap to bank 1.
    for (int y = 0; y < V; y++) do_line(y, H, 1'b0);
    check("f1_line_error", 32'(line_error_out), 32'd0);
    do_vblank(1'b1, 1'b1, 1'b1);
    check("f1_bank", 32'(wr_bank_out), 32'd1);

    // Frame 2: line 5 is one pixel short; line 6 still starts at 960.
    for (int y = 0; y < V; y++) begin
      do_line(y, (y == 5) ? H - 1 : H, 1'b0);
      if (y == 4) check("f2_line_error_before", 32'(line_error_out), 32'd0);
      if (y == 5) check("f2_line_error_l5", 32'(line_error_out), 32'd1);
    end
    do_vblank(1'b1, 1'b0, 1'b1);
    check("f2_bank_kept", 32'(wr_bank_out), 32'd1);
    check("f2_line_error_cleared", 32'(line_error_out), 32'd0);

    // Frame 3: last pixel coincident with hblank rise, then a 161-pixel line.
    do_line(0, H, 1'b1);
    check("f3_coincident_line_good", 32'(line_error_out), 32'd0);
    do_line(1, H + 1, 1'b0);
    check("f3_long_line_error", 32'(line_error_out), 32'd1);
    do_vblank(1'b1, 1'b0, 1'b1);

    // Frame 4: reset in the middle of line 70.
    for (int y = 0; y < 70; y++) do_line(y, 4, 1'b0);
    check("f4_short_lines_error", 32'(line_error_out), 32'd1);
    for (int x = 0; x < 10; x++) begin
      pixel_in       = pat(x, 70);
      pixel_valid_in = 1'b1;
      wr_q.push_back('{addr: 15'(70 * H + x), data: pat(x, 70)});
      tick();
    end
    pixel_valid_in = 1'b0;
    tick();
    rst_in = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rst_in = 1'b1;
    tick();

    // Back in SYNC: nothing written until the next vblank falling edge.
    stray_pixels(3);
    do_vblank(1'b0, 1'b0, 1'b0);
    do_line(0, 3, 1'b0);
    do_vblank(1'b1, 1'b0, 1'b0);

    repeat (4) tick();
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("ev_queue_drained", 32'(ev_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Downstream of the pixel processing unit: consumes its 2-bit shade stream with hblank/vblank markers, tracks the current (x, y) screen position, and writes each pixel into one bank of a double-buffered 160×144 framebuffer. At each clean frame end it swaps banks, so the display scan-out reads a complete, stable frame. It also flags malformed lines and frames instead of corrupting the displayed bank.

## Interface
- H_PIXELS, 160, pixels per visible line
- V_LINES, 144, visible lines per frame
- ADDR_WIDTH, 15, framebuffer address width per bank (must hold H_PIXELS*V_LINES-1)
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous, active-low reset
- pixel_in  input  2  shade index from PPU
- pixel_valid_in  input  1  pixel_in valid this cycle (single-cycle strobe)
- hblank_in  input  1  PPU in HBlank (level)
- vblank_in  input  1  PPU in VBlank (level)
- wr_addr_out  output  ADDR_WIDTH  framebuffer write address, y*H_PIXELS + x
- wr_data_out  output  2  framebuffer write data
- wr_en_out  output  1  framebuffer write strobe
- wr_bank_out  output  1  bank being written; scan-out reads the other bank
- frame_done_out  output  1  one-cycle pulse on bank swap
- line_error_out  output  1  sticky: any line with pixel count ≠ H_PIXELS this frame
- frame_error_out  output  1  one-cycle pulse when a frame ends malformed (no swap)

## Operation
- States: SYNC, ACTIVE, HBLANK, VBLANK.
- SYNC (after reset): ignore pixels; on vblank_in falling edge → ACTIVE with x=0, y=0, line_base=0.
- ACTIVE: each pixel_valid_in with x < H_PIXELS writes {line_base + x, pixel_in}, x++. Pixels with x ≥ H_PIXELS are dropped and set the line-bad flag.
- ACTIVE → HBLANK on hblank_in rising edge: if x ≠ H_PIXELS set line_error_out; y++, line_base += H_PIXELS (adder, no multiplier), x=0.
- HBLANK → ACTIVE on hblank_in falling edge while vblank_in low. Pixels in HBLANK are dropped, set line-bad.
- Any state except SYNC → VBLANK on vblank_in rising edge (checked before hblank edge in the same cycle). Frame is good iff y == V_LINES and line_error_out == 0: toggle wr_bank_out, pulse frame_done_out. Else pulse frame_error_out, keep bank.
- VBLANK → ACTIVE on vblank_in falling edge: x=0, y=0, line_base=0, line_error_out cleared.
- Lines beyond V_LINES: writes suppressed (y ≥ V_LINES), frame marked bad.
- Edge detection uses one registered copy of hblank_in/vblank_in; inputs are synchronous to clk_in.

## Timing
- All outputs registered. Reset values: wr_addr_out=0, wr_data_out=0, wr_en_out=0, wr_bank_out=0, frame_done_out=0, line_error_out=0, frame_error_out=0; state=SYNC.
- Latency: pixel_valid_in at cycle N → wr_en_out high at N+1 with matching addr/data; one write per strobe, no backpressure.
- Pixel strobe coincident with hblank rising edge: pixel written first (counts toward line), then line closes.
- frame_done_out / frame_error_out assert the cycle after vblank rising edge; wr_bank_out toggles in that same cycle.
- Reset mid-frame: outputs return to reset values immediately; resumes only after next vblank falling edge.

## Structure
- Shared package fpgaboy_pkg: H_PIXELS/V_LINES constants, lcd_writer_state_t enum; scan-out side imports the same constants.
- Sub-module EdgeDetect (rise/fall pulse, registered) instantiated twice for hblank_in and vblank_in.
- Framebuffer BRAM instantiated outside this block.

## Test plan
- Reset then full frame (vblank low, 144 lines × 160 pixels, hblank between, vblank rise) → 23040 writes, last wr_addr_out=23039, frame_done_out pulse, wr_bank_out 0→1.
- Line 5 gets 159 pixels → line_error_out set at its hblank, frame_error_out at vblank, wr_bank_out unchanged, writes for line 6 start at 960.
- 161 pixels on line 0 → 161st dropped (no wr_en_out), line_error_out=1.
- Pixels before first vblank falling edge after reset → no writes; first pixel after it writes address 0.
- Pixel strobe same cycle as hblank rise on x=159 → written at 159, line good.
- rst_in low mid-line at y=70 → all outputs 0 next cycle, bank=0, state SYNC.
